// File: rtl/issue_scoreboard_if.sv
// Issue scoreboard handshake bundle: fetch-side input, execute-side
// issue register, writeback notification and status counters.
interface issue_scoreboard_if;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [3:0]  out_r1;
    logic [3:0]  out_r2;
    logic [3:0]  out_wr;
    logic        out_regwrt;
    logic        wb_valid;
    logic [3:0]  wb_wr;
    logic        halted;
    logic [15:0] stall_cnt;
    logic [15:0] issue_cnt;

    modport slave (
        input  in_valid, in_instr, out_ready, wb_valid, wb_wr,
        output in_ready, out_valid, out_op, out_r1, out_r2,
        output out_wr, out_regwrt, halted, stall_cnt, issue_cnt
    );

    modport master (
        output in_valid, in_instr, out_ready, wb_valid, wb_wr,
        input  in_ready, out_valid, out_op, out_r1, out_r2,
        input  out_wr, out_regwrt, halted, stall_cnt, issue_cnt
    );
endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue stage with a per-register busy scoreboard (RAW/WAW).
// Optional macro WB_BYPASS_EN lets a same-cycle writeback clear a hazard.
module issue_scoreboard (
    input  logic                 clk,
    input  logic                 rst,
    issue_scoreboard_if.slave    bus
);
    typedef enum logic [1:0] {RUN, STALL, HALTED} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_busy;
    logic        r_out_valid;
    logic [3:0]  r_op;
    logic [3:0]  r_r1;
    logic [3:0]  r_r2;
    logic [3:0]  r_wr;
    logic        r_regwrt;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_issue_cnt;

    logic [3:0]  w_op;
    logic [3:0]  w_rd;
    logic [3:0]  w_rs1;
    logic [3:0]  w_rs2;
    logic        w_use1;
    logic        w_use2;
    logic        w_wrt;
    logic [15:0] w_wb_mask;
    logic [15:0] w_set_mask;
    logic [15:0] w_busy_eff;
    logic        w_hazard;
    logic        w_slot;
    logic        w_in_ready;
    logic        w_xfer;

    assign w_op  = bus.in_instr[15:12];
    assign w_rd  = bus.in_instr[11:8];
    assign w_rs1 = bus.in_instr[7:4];
    assign w_rs2 = bus.in_instr[3:0];

    always_comb begin
        w_use1 = 1'b0;
        w_use2 = 1'b0;
        w_wrt  = 1'b0;
        if (w_op >= 4'h1 && w_op <= 4'hB) begin
            w_use1 = 1'b1;
            w_use2 = 1'b1;
            w_wrt  = 1'b1;
        end else if (w_op == 4'hC) begin
            w_use1 = 1'b1;
            w_wrt  = 1'b1;
        end else if (w_op == 4'hD || w_op == 4'hE) begin
            w_use1 = 1'b1;
            w_use2 = 1'b1;
        end
    end

    assign w_wb_mask = bus.wb_valid ? (16'h0001 << bus.wb_wr) : 16'h0000;

`ifdef WB_BYPASS_EN
    assign w_busy_eff = r_busy & ~w_wb_mask;
`else
    assign w_busy_eff = r_busy;
`endif

    assign w_hazard = (w_use1 & w_busy_eff[w_rs1])
                    | (w_use2 & w_busy_eff[w_rs2])
                    | (w_wrt  & w_busy_eff[w_rd]);

    // STALL re-opens in the same cycle its hazard clears
    assign w_slot     = !r_out_valid || bus.out_ready;
    assign w_in_ready = (r_state != HALTED) && !w_hazard && w_slot;
    assign w_xfer     = bus.in_valid && w_in_ready;
    assign w_set_mask = (w_xfer && w_wrt) ? (16'h0001 << w_rd) : 16'h0000;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (w_xfer && w_op == 4'hF)
                    w_state_nxt = HALTED;
                else if (bus.in_valid && w_hazard)
                    w_state_nxt = STALL;
            end
            STALL: begin
                if (w_xfer && w_op == 4'hF)
                    w_state_nxt = HALTED;
                else if (!w_hazard)
                    w_state_nxt = RUN;
            end
            HALTED:  w_state_nxt = HALTED;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_busy      <= 16'h0000;
            r_out_valid <= 1'b0;
            r_op        <= 4'h0;
            r_r1        <= 4'h0;
            r_r2        <= 4'h0;
            r_wr        <= 4'h0;
            r_regwrt    <= 1'b0;
            r_stall_cnt <= 16'h0000;
            r_issue_cnt <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            // set wins over a same-cycle clear of the same bit
            r_busy  <= (r_busy & ~w_wb_mask) | w_set_mask;
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_op        <= w_op;
                r_r1        <= w_rs1;
                r_r2        <= w_rs2;
                r_wr        <= w_rd;
                r_regwrt    <= w_wrt;
                r_issue_cnt <= r_issue_cnt + 16'h0001;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (bus.in_valid && !w_in_ready && r_state != HALTED)
                r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_op     = r_op;
    assign bus.out_r1     = r_r1;
    assign bus.out_r2     = r_r2;
    assign bus.out_wr     = r_wr;
    assign bus.out_regwrt = r_regwrt;
    assign bus.halted     = (r_state == HALTED);
    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.issue_cnt  = r_issue_cnt;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard; expectations follow WB_BYPASS_EN.
module tb_issue_scoreboard;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   exp_stall;

    issue_scoreboard_if bus ();

    issue_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ins);
        bus.in_valid = v;
        bus.in_instr = ins;
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_oval"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_op"},   {28'd0, bus.out_op}, 32'd0);
        chk({tag, "_r1"},   {28'd0, bus.out_r1}, 32'd0);
        chk({tag, "_r2"},   {28'd0, bus.out_r2}, 32'd0);
        chk({tag, "_wr"},   {28'd0, bus.out_wr}, 32'd0);
        chk({tag, "_rwt"},  {31'd0, bus.out_regwrt}, 32'd0);
        chk({tag, "_halt"}, {31'd0, bus.halted}, 32'd0);
        chk({tag, "_stc"},  {16'd0, bus.stall_cnt}, 32'd0);
        chk({tag, "_isc"},  {16'd0, bus.issue_cnt}, 32'd0);
        chk({tag, "_busy"}, {16'd0, dut.r_busy}, 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_stall = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 16'h0000;
        bus.out_ready = 1'b1;
        bus.wb_valid  = 1'b0;
        bus.wb_wr     = 4'h0;
        tick();
        tick();
        rst = 1'b0;
        chk_reset("rst0");

        // first ALU issue: r3 <= r2, r1
        drive(1'b1, 16'h1321);
        chk("rdy_1321", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("oval_1321", {31'd0, bus.out_valid}, 32'd1);
        chk("op_1321",   {28'd0, bus.out_op}, 32'h1);
        chk("wr_1321",   {28'd0, bus.out_wr}, 32'h3);
        chk("r1_1321",   {28'd0, bus.out_r1}, 32'h2);
        chk("r2_1321",   {28'd0, bus.out_r2}, 32'h1);
        chk("rwt_1321",  {31'd0, bus.out_regwrt}, 32'd1);
        chk("busy_1321", {16'd0, dut.r_busy}, 32'h0008);
        chk("isc_1321",  {16'd0, bus.issue_cnt}, 32'd1);

        // RAW on r3
        drive(1'b1, 16'h2434);
        chk("rdy_raw", {31'd0, bus.in_ready}, 32'd0);
        tick();
        exp_stall++;
        chk("stc_raw1", {16'd0, bus.stall_cnt}, exp_stall);
        chk("oval_drain", {31'd0, bus.out_valid}, 32'd0);
        tick();
        exp_stall++;
        chk("stc_raw2", {16'd0, bus.stall_cnt}, exp_stall);
        chk("isc_raw", {16'd0, bus.issue_cnt}, 32'd1);

        bus.wb_valid = 1'b1;
        bus.wb_wr    = 4'h3;
        #1;
`ifdef WB_BYPASS_EN
        chk("rdy_wb_byp", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.wb_valid = 1'b0;
`else
        chk("rdy_wb_nobyp", {31'd0, bus.in_ready}, 32'd0);
        tick();
        exp_stall++;
        bus.wb_valid = 1'b0;
        chk("busy_wb", {16'd0, dut.r_busy}, 32'h0000);
        #1;
        chk("rdy_after_wb", {31'd0, bus.in_ready}, 32'd1);
        tick();
`endif
        chk("op_2434",  {28'd0, bus.out_op}, 32'h2);
        chk("wr_2434",  {28'd0, bus.out_wr}, 32'h4);
        chk("isc_2434", {16'd0, bus.issue_cnt}, 32'd2);
        chk("stc_2434", {16'd0, bus.stall_cnt}, exp_stall);
        chk("busy_2434", {16'd0, dut.r_busy}, 32'h0010);
        drive(1'b0, 16'h0000);
        tick();

        // backpressure from execute
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h1567);
        chk("rdy_1567", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("wr_1567", {28'd0, bus.out_wr}, 32'h5);
        drive(1'b1, 16'h3890);
        chk("rdy_bp", {31'd0, bus.in_ready}, 32'd0);
        tick();
        exp_stall++;
        chk("oval_bp", {31'd0, bus.out_valid}, 32'd1);
        chk("op_bp",   {28'd0, bus.out_op}, 32'h1);
        chk("wr_bp",   {28'd0, bus.out_wr}, 32'h5);
        chk("r1_bp",   {28'd0, bus.out_r1}, 32'h6);
        chk("stc_bp",  {16'd0, bus.stall_cnt}, exp_stall);
        bus.out_ready = 1'b1;
        #1;
        chk("rdy_bp_rel", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("op_3890", {28'd0, bus.out_op}, 32'h3);
        chk("wr_3890", {28'd0, bus.out_wr}, 32'h8);
        chk("isc_3890", {16'd0, bus.issue_cnt}, 32'd4);
        chk("busy_3890", {16'd0, dut.r_busy}, 32'h0130);

        // writeback to a free register is ignored
        drive(1'b0, 16'h0000);
        bus.wb_valid = 1'b1;
        bus.wb_wr    = 4'hA;
        tick();
        chk("busy_wbfree", {16'd0, dut.r_busy}, 32'h0130);

        // writer of r5 in the same cycle as r5 writeback
        bus.wb_wr = 4'h5;
        drive(1'b1, 16'h1521);
`ifdef WB_BYPASS_EN
        chk("rdy_1521", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.wb_valid = 1'b0;
`else
        chk("rdy_1521", {31'd0, bus.in_ready}, 32'd0);
        tick();
        exp_stall++;
        bus.wb_valid = 1'b0;
        chk("busy_1521_clr", {16'd0, dut.r_busy}, 32'h0110);
        tick();
`endif
        chk("busy_1521", {16'd0, dut.r_busy}, 32'h0130);
        chk("isc_1521",  {16'd0, bus.issue_cnt}, 32'd5);
        chk("stc_1521",  {16'd0, bus.stall_cnt}, exp_stall);

        // HALT
        drive(1'b1, 16'hF000);
        tick();
        chk("halt_set", {31'd0, bus.halted}, 32'd1);
        chk("op_halt",  {28'd0, bus.out_op}, 32'hF);
        chk("rwt_halt", {31'd0, bus.out_regwrt}, 32'd0);
        drive(1'b1, 16'h1ABC);
        chk("rdy_halt", {31'd0, bus.in_ready}, 32'd0);
        tick();
        tick();
        chk("halt_hold", {31'd0, bus.halted}, 32'd1);
        chk("stc_halt",  {16'd0, bus.stall_cnt}, exp_stall);
        chk("oval_halt", {31'd0, bus.out_valid}, 32'd0);
        chk("isc_halt",  {16'd0, bus.issue_cnt}, 32'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("halt_clr", {31'd0, bus.halted}, 32'd0);
        #1;
        chk("rdy_post_halt", {31'd0, bus.in_ready}, 32'd1);

        // stall counter wrap, then reset mid-stall
        drive(1'b1, 16'h1321);
        tick();
        drive(1'b1, 16'h2434);
        repeat (65536) tick();
        chk("stc_wrap", {16'd0, bus.stall_cnt}, 32'h0000);
        tick();
        chk("stc_wrap1", {16'd0, bus.stall_cnt}, 32'h0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 16'h0000);
        chk_reset("rst_stall");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
